proc_instr_sequencer: RTL and testbench
=======================================

Name: proc_instr_sequencer

Overview:
Program sequencer that feeds the existing 16-bit Processor (mv/mvi/add/sub) from a small writable program memory. It drives the processor's DIN and Run, inserts the mvi immediate word, and waits for Done before issuing the next instruction. It sits between a host/loader and the Processor instance, replacing hand-driven DIN/Run stimulus.

Parameters:
ADDR_W, 5, program memory address width (depth 2**ADDR_W words)
DATA_W, 16, word width; must equal the Processor DIN width
TIMEOUT, 15, maximum cycles to wait for Done before flagging Error

Ports:
clk  in  1  single clock; all state updates on rising edge
Reset  in  1  one clock; reset is synchronous and active-high
Start  in  1  pulse: begin execution at address 0 (accepted only in IDLE/HALT/ERR)
Prog_we  in  1  program memory write enable (ignored while Busy)
Prog_addr  in  ADDR_W  program memory write address
Prog_data  in  DATA_W  program memory write data
Prog_len  in  ADDR_W+1  number of words in program (sampled on accepted Start)
Done  in  1  Processor Done
DIN_out  out  DATA_W  to Processor DIN
Run  out  1  to Processor Run
Busy  out  1  high in FETCH/IMM/WAIT
Halted  out  1  high in HALT
Error  out  1  high in ERR
PC  out  ADDR_W  next word address
Instr_cnt  out  8  completed instructions since Start, saturates at 255

Behaviour:
- Instruction format: DIN[8:6]=opcode, [5:3]=Rx, [2:0]=Ry; opcodes mv=000, mvi=001, add=010, sub=011; other opcodes issued unchanged (treated as non-mvi).
- States: IDLE, FETCH, IMM, WAIT, HALT, ERR. Outputs are Moore-decoded from state; memory read is asynchronous (DIN_out = mem[PC] where stated).
- Reset: state=IDLE, PC=0, Instr_cnt=0, Run=0, DIN_out=0, Busy/Halted/Error=0, wait counter=0, latched length=0. Memory contents are not cleared.
- IDLE/HALT/ERR + Start: latch Prog_len, PC=0, Instr_cnt=0, clear counter; go FETCH if Prog_len!=0, else HALT.
- FETCH (1 cycle): Run=1, DIN_out=mem[PC]; PC<=PC+1; next IMM if opcode==mvi, else WAIT.
- IMM (1 cycle): Run=0, DIN_out=mem[PC]; PC<=PC+1. If opcode-word was the last word (PC==len on entry) -> ERR (truncated mvi), no immediate issued. Done sampled here: if Done=1, the instruction completes (see completion rule) instead of entering WAIT.
- WAIT: Run=0, DIN_out=0; counter increments each cycle; Done=1 -> completion; counter reaching TIMEOUT with Done=0 -> ERR.
- Completion: Instr_cnt+1 (saturating); clear counter; next HALT if PC==len, else FETCH. Back-to-back: FETCH directly follows the completion cycle, no bubble.
- Latency: Start at edge k -> Run=1 during cycle k+1. mv issues Run for exactly 1 cycle; mvi presents opcode then immediate on consecutive cycles.
- Done while not in IMM/WAIT is ignored. Start while Busy is ignored. Prog_we while Busy is ignored; allowed in IDLE/HALT/ERR.
- PC wrap: len=2**ADDR_W runs all words; PC wraps to 0 after the last word, and HALT is detected by comparing the (ADDR_W+1)-bit word count, not PC alone.
- Reset mid-instruction: immediate return to IDLE, Run dropped the same cycle after the edge; the Processor is reset by the same system reset.

Decomposition:
- Package proc_seq_pkg: opcode constants OP_MV/OP_MVI/OP_ADD/OP_SUB, opcode field positions, state encoding.
- Sub-module proc_prog_mem: 2**ADDR_W x DATA_W, synchronous write, asynchronous read.

Test Plan:
- Program {0x0040, 0xAAAA, 0x0008, 0x0040, 0x5555, 0x0081, 0x00C1}, len=7, with the real Processor -> R0=0xFFFF after add, 0x5555 after sub, Instr_cnt=5, Halted=1, Error=0.
- Start with len=0 -> HALT next cycle, Run never asserted, Instr_cnt=0.
- Program {0x0040}, len=1 (truncated mvi) -> one Run pulse, then Error=1, Busy=0; a new Start clears Error.
- Stub Done held low after mv -> Error=1 exactly TIMEOUT cycles after entering WAIT.
- Reset asserted during WAIT of an add -> next cycle IDLE, Run=0, PC=0; memory still holds the program, so a rerun produces identical results.
- Prog_we and Start during Busy -> memory unchanged, execution unaffected; Done pulse in IDLE -> no state change.

Source files
------------

// File: rtl/proc_seq_pkg.sv
// Shared definitions for the Processor program sequencer: opcode values,
// instruction field positions and the sequencer state encoding.
package proc_seq_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int unsigned OPC_HI = 8;
   localparam int unsigned OPC_LO = 6;
   localparam int unsigned RX_HI  = 5;
   localparam int unsigned RX_LO  = 3;
   localparam int unsigned RY_HI  = 2;
   localparam int unsigned RY_LO  = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_IMM,
      S_WAIT,
      S_HALT,
      S_ERR
   } state_t;

endpackage

// File: rtl/proc_instr_sequencer_if.sv
// Sequencer-to-Processor instruction handshake: instruction word, Run strobe
// and the Processor's Done response.
interface proc_instr_sequencer_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] DIN_out;
   logic              Run;
   logic              Done;

   modport master (output DIN_out, output Run, input Done);
   modport slave  (input DIN_out, input Run, output Done);
endinterface

// File: rtl/proc_prog_mem.sv
// Program store for the sequencer: synchronous write port, asynchronous read
// port. Contents are deliberately not cleared by reset.
module proc_prog_mem #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/proc_instr_sequencer.sv
// Feeds the 16-bit Processor from program memory: issues each instruction with
// Run, inserts the mvi immediate word, and waits for Done (bounded by TIMEOUT).
module proc_instr_sequencer
   import proc_seq_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   Reset,
   input  logic                   Start,
   input  logic                   Prog_we,
   input  logic [ADDR_W-1:0]      Prog_addr,
   input  logic [DATA_W-1:0]      Prog_data,
   input  logic [ADDR_W:0]        Prog_len,
   proc_instr_sequencer_if.master proc,
   output logic                   Busy,
   output logic                   Halted,
   output logic                   Error,
   output logic [ADDR_W-1:0]      PC,
   output logic [7:0]             Instr_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);
   localparam logic [ADDR_W:0] WONE = (ADDR_W + 1)'(1);

   state_t            state;
   state_t            nxt;
   logic [ADDR_W:0]   wcnt;
   logic [ADDR_W:0]   wcnt_nx;
   logic [ADDR_W:0]   len;
   logic [TW-1:0]     tcnt;
   logic [DATA_W-1:0] rdata;
   logic              run_q;
   logic              last;
   logic              adv;
   logic              cmpl;

   proc_prog_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (Prog_we && !Busy),
      .waddr (Prog_addr),
      .wdata (Prog_data),
      .raddr (PC),
      .rdata (rdata)
   );

   // Word count is one bit wider than PC so a full 2**ADDR_W program can end
   // with PC wrapped to zero and still be recognised as complete.
   assign PC   = wcnt[ADDR_W-1:0];
   assign last = (wcnt == len);

   assign proc.Run     = run_q;
   assign proc.DIN_out = (state == S_FETCH || (state == S_IMM && !last)) ? rdata : '0;

   always_comb begin
      nxt  = state;
      adv  = 1'b0;
      cmpl = 1'b0;
      unique case (state)
         S_IDLE, S_HALT, S_ERR: begin
            if (Start) begin
               nxt = (Prog_len != '0) ? S_FETCH : S_HALT;
            end
         end
         S_FETCH: begin
            adv = 1'b1;
            nxt = (rdata[OPC_HI:OPC_LO] == OP_MVI) ? S_IMM : S_WAIT;
         end
         S_IMM: begin
            if (last) begin
               nxt = S_ERR;
            end else begin
               adv = 1'b1;
               if (proc.Done) cmpl = 1'b1;
               else           nxt  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (proc.Done)         cmpl = 1'b1;
            else if (tcnt == TMAX) nxt  = S_ERR;
         end
         default: nxt = S_IDLE;
      endcase
      wcnt_nx = adv ? (wcnt + WONE) : wcnt;
      if (cmpl) begin
         nxt = (wcnt_nx == len) ? S_HALT : S_FETCH;
      end
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         len       <= '0;
         tcnt      <= '0;
         Instr_cnt <= '0;
         run_q     <= 1'b0;
         Busy      <= 1'b0;
         Halted    <= 1'b0;
         Error     <= 1'b0;
      end else begin
         state  <= nxt;
         run_q  <= (nxt == S_FETCH);
         Busy   <= (nxt == S_FETCH) || (nxt == S_IMM) || (nxt == S_WAIT);
         Halted <= (nxt == S_HALT);
         Error  <= (nxt == S_ERR);
         if ((state == S_IDLE || state == S_HALT || state == S_ERR) && Start) begin
            len       <= Prog_len;
            wcnt      <= '0;
            tcnt      <= '0;
            Instr_cnt <= '0;
         end else begin
            wcnt <= wcnt_nx;
            if (cmpl) begin
               tcnt      <= '0;
               Instr_cnt <= (Instr_cnt == 8'hFF) ? Instr_cnt : Instr_cnt + 8'd1;
            end else if (state == S_WAIT) begin
               tcnt <= tcnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Bench for proc_instr_sequencer with a small behavioural Processor model
// (mv/mvi/add/sub) or a stubbed Done line on the handshake interface.
module tb_proc_instr_sequencer;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              Reset;
   logic              Start;
   logic              Prog_we;
   logic [ADDR_W-1:0] Prog_addr;
   logic [DATA_W-1:0] Prog_data;
   logic [ADDR_W:0]   Prog_len;
   logic              Busy, Halted, Error;
   logic [ADDR_W-1:0] PC;
   logic [7:0]        Instr_cnt;

   int checks = 0;
   int errors = 0;
   int runs   = 0;

   always #5 clk = ~clk;

   proc_instr_sequencer_if #(.DATA_W(DATA_W)) bus ();

   proc_instr_sequencer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .Reset     (Reset),
      .Start     (Start),
      .Prog_we   (Prog_we),
      .Prog_addr (Prog_addr),
      .Prog_data (Prog_data),
      .Prog_len  (Prog_len),
      .proc      (bus),
      .Busy      (Busy),
      .Halted    (Halted),
      .Error     (Error),
      .PC        (PC),
      .Instr_cnt (Instr_cnt)
   );

   // Processor model: mv/mvi finish one cycle after issue, add/sub after three.
   logic [15:0] R [8];
   logic [15:0] ir, A, G;
   logic [2:0]  ms = 3'd0;
   logic        stub_en, stub_done, model_done;

   assign model_done = (ms == 3'd1) || (ms == 3'd2) || (ms == 3'd5) || (ms == 3'd6);
   assign bus.Done   = stub_en ? stub_done : model_done;

   always @(posedge clk) begin
      if (bus.Run) runs <= runs + 1;
      if (Reset) begin
         ms <= 3'd0;
      end else begin
         case (ms)
            3'd0: if (bus.Run) begin
               ir <= bus.DIN_out;
               case (bus.DIN_out[8:6])
                  3'b000:         ms <= 3'd2;
                  3'b001:         ms <= 3'd1;
                  3'b010, 3'b011: ms <= 3'd3;
                  default:        ms <= 3'd6;
               endcase
            end
            3'd1: begin R[ir[5:3]] <= bus.DIN_out; ms <= 3'd0; end
            3'd2: begin R[ir[5:3]] <= R[ir[2:0]];  ms <= 3'd0; end
            3'd3: begin A <= R[ir[5:3]];           ms <= 3'd4; end
            3'd4: begin
               G  <= ir[6] ? (A - R[ir[2:0]]) : (A + R[ir[2:0]]);
               ms <= 3'd5;
            end
            3'd5: begin R[ir[5:3]] <= G; ms <= 3'd0; end
            default: ms <= 3'd0;
         endcase
      end
   end

   typedef struct {
      string       name;
      int          len;
      int          nw;
      logic [15:0] w [32];
      int          cnt;
      int          halted;
      int          error;
      int          pc;
      int          nrun;
      int          ridx;
      logic [15:0] rval;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic write_word(input int a, input logic [15:0] d);
      @(negedge clk);
      Prog_we   = 1'b1;
      Prog_addr = ADDR_W'(a);
      Prog_data = d;
      @(negedge clk);
      Prog_we   = 1'b0;
   endtask

   task automatic start_pulse(input int len);
      @(negedge clk);
      Start    = 1'b1;
      Prog_len = (ADDR_W + 1)'(len);
      @(negedge clk);
      Start    = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (Busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check({nm, " busy_timeout"}, 32'(Busy), 32'd0);
   endtask

   task automatic wait_cnt(input string nm, input int target);
      int n = 0;
      while (32'(Instr_cnt) != target && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) check({nm, " cnt_timeout"}, 32'(Instr_cnt), 32'(target));
   endtask

   task automatic load_main();
      write_word(0, 16'h0040); write_word(1, 16'hAAAA); write_word(2, 16'h0008);
      write_word(3, 16'h0040); write_word(4, 16'h5555); write_word(5, 16'h0081);
      write_word(6, 16'h00C1);
   endtask

   initial begin
      int r0;
      int n;

      tbl[0].name = "main";   tbl[0].len = 7;  tbl[0].nw = 7;
      tbl[0].w[0] = 16'h0040; tbl[0].w[1] = 16'hAAAA; tbl[0].w[2] = 16'h0008;
      tbl[0].w[3] = 16'h0040; tbl[0].w[4] = 16'h5555; tbl[0].w[5] = 16'h0081;
      tbl[0].w[6] = 16'h00C1;
      tbl[0].cnt = 5; tbl[0].halted = 1; tbl[0].error = 0; tbl[0].pc = 7;
      tbl[0].nrun = 5; tbl[0].ridx = 0; tbl[0].rval = 16'h5555;

      tbl[1].name = "mv1";    tbl[1].len = 1;  tbl[1].nw = 1; tbl[1].w[0] = 16'h0008;
      tbl[1].cnt = 1; tbl[1].halted = 1; tbl[1].error = 0; tbl[1].pc = 1;
      tbl[1].nrun = 1; tbl[1].ridx = 1; tbl[1].rval = 16'h5555;

      tbl[2].name = "len0";   tbl[2].len = 0;  tbl[2].nw = 0;
      tbl[2].cnt = 0; tbl[2].halted = 1; tbl[2].error = 0; tbl[2].pc = 0;
      tbl[2].nrun = 0; tbl[2].ridx = 8; tbl[2].rval = 16'h0000;

      tbl[3].name = "trunc";  tbl[3].len = 1;  tbl[3].nw = 1; tbl[3].w[0] = 16'h0040;
      tbl[3].cnt = 0; tbl[3].halted = 0; tbl[3].error = 1; tbl[3].pc = 1;
      tbl[3].nrun = 1; tbl[3].ridx = 8; tbl[3].rval = 16'h0000;

      tbl[4].name = "add3";   tbl[4].len = 5;  tbl[4].nw = 5;
      tbl[4].w[0] = 16'h0050; tbl[4].w[1] = 16'h0003; tbl[4].w[2] = 16'h0058;
      tbl[4].w[3] = 16'h0004; tbl[4].w[4] = 16'h0093;
      tbl[4].cnt = 3; tbl[4].halted = 1; tbl[4].error = 0; tbl[4].pc = 5;
      tbl[4].nrun = 3; tbl[4].ridx = 2; tbl[4].rval = 16'h0007;

      tbl[5].name = "wrap32"; tbl[5].len = 32; tbl[5].nw = 32;
      for (int j = 0; j < 32; j++) tbl[5].w[j] = 16'h0008;
      tbl[5].cnt = 32; tbl[5].halted = 1; tbl[5].error = 0; tbl[5].pc = 0;
      tbl[5].nrun = 32; tbl[5].ridx = 8; tbl[5].rval = 16'h0000;

      Reset = 1'b1; Start = 1'b0; Prog_we = 1'b0; Prog_addr = '0;
      Prog_data = '0; Prog_len = '0; stub_en = 1'b0; stub_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst run",    32'(bus.Run),     32'd0);
      check("rst din",    32'(bus.DIN_out), 32'd0);
      check("rst busy",   32'(Busy),        32'd0);
      check("rst halted", 32'(Halted),      32'd0);
      check("rst error",  32'(Error),       32'd0);
      check("rst pc",     32'(PC),          32'd0);
      check("rst cnt",    32'(Instr_cnt),   32'd0);
      Reset = 1'b0;

      // Done while idle must be ignored
      stub_en = 1'b1; stub_done = 1'b1;
      @(negedge clk);
      stub_done = 1'b0; stub_en = 1'b0;
      @(negedge clk);
      check("idle_done busy",   32'(Busy),      32'd0);
      check("idle_done halted", 32'(Halted),    32'd0);
      check("idle_done error",  32'(Error),     32'd0);
      check("idle_done pc",     32'(PC),        32'd0);
      check("idle_done cnt",    32'(Instr_cnt), 32'd0);

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < tbl[i].nw; j++) write_word(j, tbl[i].w[j]);
         r0 = runs;
         start_pulse(tbl[i].len);
         wait_idle(tbl[i].name);
         check({tbl[i].name, " cnt"},    32'(Instr_cnt), 32'(tbl[i].cnt));
         check({tbl[i].name, " halted"}, 32'(Halted),    32'(tbl[i].halted));
         check({tbl[i].name, " error"},  32'(Error),     32'(tbl[i].error));
         check({tbl[i].name, " pc"},     32'(PC),        32'(tbl[i].pc));
         check({tbl[i].name, " runs"},   32'(runs - r0), 32'(tbl[i].nrun));
         if (tbl[i].ridx < 8)
            check({tbl[i].name, " reg"}, 32'(R[tbl[i].ridx]), 32'(tbl[i].rval));
      end

      // Truncated mvi, then a fresh Start clears Error; Start-to-Run latency is one cycle
      write_word(0, 16'h0040);
      start_pulse(1);
      wait_idle("trunc2");
      check("trunc2 error", 32'(Error), 32'd1);
      check("trunc2 busy",  32'(Busy),  32'd0);
      write_word(0, 16'h0008);
      start_pulse(1);
      check("restart error", 32'(Error),   32'd0);
      check("latency run",   32'(bus.Run), 32'd1);
      check("latency din",   32'(bus.DIN_out), 32'h0008);
      @(negedge clk);
      check("mv run width",  32'(bus.Run), 32'd0);
      wait_idle("restart");
      check("restart cnt",   32'(Instr_cnt), 32'd1);

      // Done stuck low after mv: Error exactly TIMEOUT cycles after WAIT entry
      stub_en = 1'b1; stub_done = 1'b0;
      start_pulse(1);
      repeat (TIMEOUT) @(posedge clk);
      #1;
      check("timeout early error", 32'(Error), 32'd0);
      check("timeout early busy",  32'(Busy),  32'd1);
      @(posedge clk);
      #1;
      check("timeout error", 32'(Error),     32'd1);
      check("timeout cnt",   32'(Instr_cnt), 32'd0);
      stub_en = 1'b0;

      // Reset during the WAIT of the add, then rerun from retained memory
      load_main();
      start_pulse(7);
      wait_cnt("rstadd", 3);
      n = 0;
      while (!bus.Run && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("rstadd run_timeout", 32'(bus.Run), 32'd1);
      @(negedge clk);
      check("rstadd in_wait busy", 32'(Busy),    32'd1);
      check("rstadd in_wait run",  32'(bus.Run), 32'd0);
      Reset = 1'b1;
      @(negedge clk);
      check("rstadd run",  32'(bus.Run),   32'd0);
      check("rstadd busy", 32'(Busy),      32'd0);
      check("rstadd pc",   32'(PC),        32'd0);
      check("rstadd cnt",  32'(Instr_cnt), 32'd0);
      Reset = 1'b0;
      start_pulse(7);
      wait_cnt("rerun", 4);
      check("rerun r0 after add", 32'(R[0]), 32'h0000FFFF);
      wait_idle("rerun");
      check("rerun cnt",    32'(Instr_cnt), 32'd5);
      check("rerun halted", 32'(Halted),    32'd1);
      check("rerun r0",     32'(R[0]),      32'h00005555);

      // Prog_we and Start while Busy are ignored
      start_pulse(7);
      Prog_we = 1'b1; Prog_addr = '0; Prog_data = 16'hFFFF;
      Start = 1'b1; Prog_len = 6'd1;
      @(negedge clk);
      Prog_we = 1'b0; Start = 1'b0;
      wait_idle("busy_we");
      check("busy_we cnt", 32'(Instr_cnt), 32'd5);
      check("busy_we pc",  32'(PC),        32'd7);
      check("busy_we r0",  32'(R[0]),      32'h00005555);
      start_pulse(7);
      wait_idle("mem_kept");
      check("mem_kept cnt",    32'(Instr_cnt), 32'd5);
      check("mem_kept r1",     32'(R[1]),      32'h0000AAAA);
      check("mem_kept halted", 32'(Halted),    32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
